// File: rtl/axo_fetch_unit_pkg.sv
// Shared types for the axo fetch stage.
// Halfword queue entries, fetch FSM states, insn length code.
package axo_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_t;

  localparam logic [1:0] RV_INSN_LEN32 = 2'b11;

  typedef struct packed {
    logic        fault;
    logic [15:0] data;
  } hw_t;

endpackage

// File: rtl/axo_fetch_unit_queue.sv
// Halfword circular FIFO between the bus side and insn assembly.
// Up to two halfwords pushed and popped per cycle.
module axo_fetch_unit_queue
  import axo_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [1:0]                   push_n,
  input  hw_t                          push_0,
  input  hw_t                          push_1,
  input  logic [1:0]                   pop_n,
  output hw_t                          h0,
  output hw_t                          h1,
  output logic [1:0]                   avail,
  output logic [$clog2(2*DEPTH):0]     free
);
  localparam int N  = 2 * DEPTH;
  localparam int AW = $clog2(N);
  localparam logic [AW:0] QN  = N;
  localparam logic [AW:0] TWO = 2;

  hw_t         mem [N];
  logic [AW:0] wr;
  logic [AW:0] rd;
  logic [AW:0] wr1;
  logic [AW:0] rd1;
  logic [AW:0] cnt;

  // Extra pointer bit distinguishes full from empty.
  assign cnt = wr - rd;
  assign wr1 = wr + 1'b1;
  assign rd1 = rd + 1'b1;
  assign h0 = mem[rd[AW-1:0]];
  assign h1 = mem[rd1[AW-1:0]];
  assign avail = (cnt >= TWO) ? 2'd2 : cnt[1:0];
  assign free = QN - cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr <= '0;
      rd <= '0;
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else if (flush) begin
      wr <= '0;
      rd <= '0;
    end else begin
      if (push_n != 2'd0) mem[wr[AW-1:0]] <= push_0;
      if (push_n == 2'd2) mem[wr1[AW-1:0]] <= push_1;
      wr <= wr + (AW+1)'(push_n);
      rd <= rd + (AW+1)'(pop_n);
    end
  end

endmodule

// File: rtl/axo_fetch_unit.sv
// Instruction fetch stage: word fetch FSM, halfword buffering,
// 16/32-bit insn assembly and redirect handling.
module axo_fetch_unit
  import axo_fetch_unit_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_re,
  output logic [29:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err,
  input  logic        redirect,
  input  logic [30:0] redirect_pc,
  output logic        insn_valid,
  input  logic        insn_ready,
  output logic [31:0] insn,
  output logic [30:0] insn_pc,
  output logic        insn_fault
);
  localparam int AW = $clog2(2 * DEPTH);
  localparam logic [AW:0] NEED = 2;

  fetch_state_t state;
  fetch_state_t state_nx;
  logic         pend;
  logic [29:0]  addr_q;
  logic [30:0]  fpc;
  logic         issue;
  logic         resp;
  logic         fire;
  logic [1:0]   push_n;
  logic [1:0]   npop;
  logic [1:0]   pop_n;
  hw_t          push_0;
  hw_t          push_1;
  hw_t          h0;
  hw_t          h1;
  logic [1:0]   avail;
  logic [AW:0]  free;

  assign issue = (state == ST_RUN) && !pend && (free >= NEED);
  assign mem_re = !rst && (pend || issue);
  assign mem_addr = pend ? addr_q : fpc[30:1];
  assign resp = mem_re && mem_ready;
  assign fire = insn_valid && insn_ready;
  assign pop_n = fire ? npop : 2'd0;

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_RUN: begin
        if (redirect)
          state_nx = (mem_re && !mem_ready) ? ST_DRAIN : ST_RUN;
        else if (resp && mem_err)
          state_nx = ST_HALT;
      end
      ST_DRAIN: if (resp) state_nx = ST_RUN;
      ST_HALT:  if (redirect) state_nx = ST_RUN;
      default:  state_nx = ST_RUN;
    endcase
  end

  // A word fetched for an odd-halfword PC only contributes its upper half.
  always_comb begin
    push_n = 2'd0;
    push_0 = '0;
    push_1 = '0;
    if (state == ST_RUN && resp && !redirect) begin
      if (mem_err) begin
        push_n = 2'd2;
        push_0 = '{fault: 1'b1, data: 16'h0};
        push_1 = '{fault: 1'b1, data: 16'h0};
      end else if (fpc[0]) begin
        push_n = 2'd1;
        push_0 = '{fault: 1'b0, data: mem_rdata[31:16]};
      end else begin
        push_n = 2'd2;
        push_0 = '{fault: 1'b0, data: mem_rdata[15:0]};
        push_1 = '{fault: 1'b0, data: mem_rdata[31:16]};
      end
    end
  end

  always_comb begin
    insn_valid = 1'b0;
    insn_fault = 1'b0;
    insn = '0;
    npop = 2'd0;
    if (avail != 2'd0) begin
      if (h0.fault) begin
        insn_valid = 1'b1;
        insn_fault = 1'b1;
        npop = (avail == 2'd2 && h1.fault) ? 2'd2 : 2'd1;
      end else if (h0.data[1:0] == RV_INSN_LEN32) begin
        if (avail == 2'd2) begin
          insn_valid = 1'b1;
          insn_fault = h1.fault;
          insn = {h1.data, h0.data};
          npop = 2'd2;
        end
      end else begin
        insn_valid = 1'b1;
        insn = {16'h0, h0.data};
        npop = 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_RUN;
      pend    <= 1'b0;
      addr_q  <= '0;
      fpc     <= RESET_VEC[31:1];
      insn_pc <= RESET_VEC[31:1];
    end else begin
      state  <= state_nx;
      pend   <= mem_re && !mem_ready;
      addr_q <= mem_addr;
      if (redirect)
        fpc <= redirect_pc;
      else if (state == ST_RUN && resp && !mem_err)
        fpc <= {fpc[30:1] + 30'd1, 1'b0};
      if (redirect)
        insn_pc <= redirect_pc;
      else if (fire)
        insn_pc <= insn_pc + 31'(npop);
    end
  end

  axo_fetch_unit_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk    (clk),
    .rst    (rst),
    .flush  (redirect),
    .push_n (push_n),
    .push_0 (push_0),
    .push_1 (push_1),
    .pop_n  (pop_n),
    .h0     (h0),
    .h1     (h1),
    .avail  (avail),
    .free   (free)
  );

endmodule
